// File: rtl/choose_split_pkg.sv
// ---------------------------------------------------------------------------
// choose_split_pkg
// Shared definitions for the choose_split block: default word width and the
// 2-bit FSM state encoding (IDLE / SHIFT / DONE).
// ---------------------------------------------------------------------------
package choose_split_pkg;

    // Default word width for choose-family blocks.
    localparam int DEFAULT_WIDTH = 8;

    // FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : choose_split_pkg

// File: rtl/choose_split_lane.sv
// ---------------------------------------------------------------------------
// choose_split_lane
// One compacting accumulator. Each enabled cycle it deposits bit_in at the
// next free position (acc[count]) and increments count, so the bits that
// belong to this lane end up packed LSB-first.
//
// Ports:
//   clk     in   1      clock, rising edge
//   rst_n   in   1      synchronous active-low reset
//   clr     in   1      clear accumulator and count (start of a word)
//   en      in   1      deposit bit_in this cycle
//   bit_in  in   1      bit to deposit
//   acc     out  WIDTH  compacted bits, unused upper bits are 0
//   count   out  CW     number of bits deposited so far
// ---------------------------------------------------------------------------
module choose_split_lane #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] acc,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] acc_r;
    logic [CW-1:0]    count_r;

    // Accumulator and fill count; a clear takes priority over a deposit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r   <= {WIDTH{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (clr) begin
            acc_r   <= {WIDTH{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (en) begin
            // Decoded write keeps the index in range even though count
            // can reach WIDTH (it never does while en is high).
            for (int i = 0; i < WIDTH; i++) begin
                if (count_r == CW'(i)) begin
                    acc_r[i] <= bit_in;
                end
            end
            count_r <= count_r + CW'(1);
        end
    end

    assign acc   = acc_r;
    assign count = count_r;

endmodule : choose_split_lane

// File: rtl/choose_split.sv
// ---------------------------------------------------------------------------
// choose_split
// Sequential inverse of choose(mask, b, c): splits data into the bits selected
// by mask=1 (lane b) and mask=0 (lane c), compacting each lane LSB-first.
// One bit is examined per cycle; a word takes WIDTH SHIFT cycles.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      mask/data valid
//   in_ready   out  1      block can accept a word (registered, IDLE only)
//   mask       in   WIDTH  1 = lane b, 0 = lane c
//   data       in   WIDTH  chosen word to split
//   out_valid  out  1      result valid (registered, DONE only)
//   out_ready  in   1      downstream accepts result
//   b_out      out  WIDTH  lane-b bits compacted, upper bits 0
//   c_out      out  WIDTH  lane-c bits compacted, upper bits 0
//   b_count    out  CW     number of mask bits equal to 1
//   c_count    out  CW     number of mask bits equal to 0
// ---------------------------------------------------------------------------
module choose_split
    import choose_split_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] mask,
    input  logic [WIDTH-1:0] data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] c_out,
    output logic [CW-1:0]    b_count,
    output logic [CW-1:0]    c_count
);

    localparam int            IW       = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    state_t           state_r;
    state_t           state_next_s;
    logic [IW-1:0]    idx_r;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] data_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             in_ready_next_s;
    logic             out_valid_next_s;
    logic             accept_s;
    logic             shift_en_s;
    logic             last_s;
    logic             b_en_s;
    logic             c_en_s;

    // Acceptance is decided from state alone, so in_ready never depends on
    // in_valid combinationally.
    assign accept_s   = (state_r == ST_IDLE) && in_valid;
    assign shift_en_s = (state_r == ST_SHIFT);
    assign last_s     = shift_en_s && (idx_r == LAST_IDX);

    // The shift registers always present the current bit at position 0.
    assign b_en_s = shift_en_s &&  mask_r[0];
    assign c_en_s = shift_en_s && !mask_r[0];

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode, computed from the next state so the handshake
    // flags can be registered and still line up with the state register.
    always_comb begin
        in_ready_next_s  = 1'b0;
        out_valid_next_s = 1'b0;
        case (state_next_s)
            ST_IDLE: begin
                in_ready_next_s  = 1'b1;
                out_valid_next_s = 1'b0;
            end
            ST_SHIFT: begin
                in_ready_next_s  = 1'b0;
                out_valid_next_s = 1'b0;
            end
            ST_DONE: begin
                in_ready_next_s  = 1'b0;
                out_valid_next_s = 1'b1;
            end
            default: begin
                in_ready_next_s  = 1'b0;
                out_valid_next_s = 1'b0;
            end
        endcase
    end

    // Registered handshake flags; in_ready is 1 straight out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_next_s;
            out_valid_r <= out_valid_next_s;
        end
    end

    // Bit index and mask/data shift registers. The index holds at the last
    // position instead of wrapping; it is reloaded on the next acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_r  <= {IW{1'b0}};
            mask_r <= {WIDTH{1'b0}};
            data_r <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            idx_r  <= {IW{1'b0}};
            mask_r <= mask;
            data_r <= data;
        end else if (shift_en_s) begin
            if (!last_s) begin
                idx_r <= idx_r + IW'(1);
            end else begin
                idx_r <= idx_r;
            end
            mask_r <= {1'b0, mask_r[WIDTH-1:1]};
            data_r <= {1'b0, data_r[WIDTH-1:1]};
        end else begin
            idx_r  <= idx_r;
            mask_r <= mask_r;
            data_r <= data_r;
        end
    end

    choose_split_lane #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_lane_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (accept_s),
        .en     (b_en_s),
        .bit_in (data_r[0]),
        .acc    (b_out),
        .count  (b_count)
    );

    choose_split_lane #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_lane_c (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (accept_s),
        .en     (c_en_s),
        .bit_in (data_r[0]),
        .acc    (c_out),
        .count  (c_count)
    );

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;

endmodule : choose_split

// File: tb/tb_choose_split.sv
// ---------------------------------------------------------------------------
// tb_choose_split
// Directed table of hand-computed split results, hand-written sequences for
// backpressure and mid-word reset, and a random round-trip sweep.
// ---------------------------------------------------------------------------
module tb_choose_split;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  mask;
    logic [W-1:0]  data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  b_out;
    logic [W-1:0]  c_out;
    logic [CW-1:0] b_count;
    logic [CW-1:0] c_count;

    int checks;
    int failures;

    choose_split #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mask      (mask),
        .data      (data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .b_out     (b_out),
        .c_out     (c_out),
        .b_count   (b_count),
        .c_count   (c_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] m;
        logic [W-1:0] d;
        logic [W-1:0] eb;
        logic [W-1:0] ec;
        int           ebc;
        int           ecc;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Quiet check for the bulk sweep: counts every comparison, prints only on failure.
    task automatic check_q(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    function automatic logic [W-1:0] deposit(input logic [W-1:0] v, input logic [W-1:0] m);
        logic [W-1:0] r;
        int j;
        r = '0;
        j = 0;
        for (int i = 0; i < W; i++) begin
            if (m[i]) begin
                r[i] = v[j];
                j++;
            end
        end
        return r;
    endfunction

    function automatic int popcnt(input logic [W-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < W; i++) n += int'(v[i]);
        return n;
    endfunction

    // Present a word, wait for the result (bounded). lat = edges after the
    // acceptance edge until out_valid is seen; -1 on timeout. Leaves result
    // unconsumed with out_ready low.
    task automatic start_word(input logic [W-1:0] m, input logic [W-1:0] d, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        mask     = m;
        data     = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    // Consume the pending result with a single-cycle out_ready.
    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [W-1:0] hb, hc, hm, hd;
        logic [W-1:0] rm, rd, recon;

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mask      = '0;
        data      = '0;

        vecs[0] = '{m: 8'h0C, d: 8'h0E, eb: 8'h03, ec: 8'h02, ebc: 2, ecc: 6};
        vecs[1] = '{m: 8'hFF, d: 8'h00, eb: 8'h00, ec: 8'h00, ebc: 8, ecc: 0};
        vecs[2] = '{m: 8'h00, d: 8'h64, eb: 8'h00, ec: 8'h64, ebc: 0, ecc: 8};
        vecs[3] = '{m: 8'hAA, d: 8'hF0, eb: 8'h0C, ec: 8'h0C, ebc: 4, ecc: 4};
        vecs[4] = '{m: 8'h0F, d: 8'h5A, eb: 8'h0A, ec: 8'h05, ebc: 4, ecc: 4};
        vecs[5] = '{m: 8'h81, d: 8'hC3, eb: 8'h03, ec: 8'h21, ebc: 2, ecc: 6};

        repeat (3) @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_b_out", 32'(b_out), 32'd0);
        check("reset_c_out", 32'(c_out), 32'd0);
        check("reset_counts", {b_count, c_count}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table.
        for (int v = 0; v < 6; v++) begin
            start_word(vecs[v].m, vecs[v].d, lat);
            // out_valid first seen 8 edges after acceptance: 9 cycles counting the accept cycle.
            check($sformatf("latency_v%0d", v), 32'(lat + 1), 32'(W + 1));
            check($sformatf("in_ready_done_v%0d", v), 32'(in_ready), 32'd0);
            check($sformatf("b_out_v%0d", v), 32'(b_out), 32'(vecs[v].eb));
            check($sformatf("c_out_v%0d", v), 32'(c_out), 32'(vecs[v].ec));
            check($sformatf("b_count_v%0d", v), 32'(b_count), 32'(vecs[v].ebc));
            check($sformatf("c_count_v%0d", v), 32'(c_count), 32'(vecs[v].ecc));
            consume();
            check($sformatf("out_valid_drop_v%0d", v), 32'(out_valid), 32'd0);
            check($sformatf("in_ready_back_v%0d", v), 32'(in_ready), 32'd1);
            check($sformatf("b_out_kept_v%0d", v), 32'(b_out), 32'(vecs[v].eb));
        end

        // Backpressure: hold the result for 5 cycles, pulse in_valid meanwhile.
        start_word(8'hAA, 8'hF0, lat);
        check("bp_latency", 32'(lat + 1), 32'(W + 1));
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                mask     = 8'h55;
                data     = 8'hFF;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check($sformatf("bp_out_valid_%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("bp_in_ready_%0d", k), 32'(in_ready), 32'd0);
            check($sformatf("bp_b_out_%0d", k), 32'(b_out), 32'h0C);
            check($sformatf("bp_c_out_%0d", k), 32'(c_out), 32'h0C);
            check($sformatf("bp_counts_%0d", k), {b_count, c_count}, {4'd4, 4'd4});
        end
        in_valid = 1'b0;
        consume();
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        // The ignored pulse must not have started a word.
        repeat (W + 2) @(negedge clk);
        check("bp_no_ghost_out_valid", 32'(out_valid), 32'd0);
        check("bp_no_ghost_in_ready", 32'(in_ready), 32'd1);

        // Reset on the 4th SHIFT cycle.
        mask     = 8'hFF;
        data     = 8'hFF;
        in_valid = 1'b1;
        @(negedge clk);          // acceptance edge passed
        in_valid = 1'b0;
        repeat (3) @(negedge clk); // three SHIFT edges passed
        check("pre_reset_partial", 32'(b_out), 32'h07);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_b_out", 32'(b_out), 32'd0);
        check("midreset_c_out", 32'(c_out), 32'd0);
        check("midreset_counts", {b_count, c_count}, 32'd0);
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        start_word(8'h0F, 8'h5A, lat);
        check("postreset_latency", 32'(lat + 1), 32'(W + 1));
        check("postreset_b_out", 32'(b_out), 32'h0A);
        check("postreset_c_out", 32'(c_out), 32'h05);
        consume();

        // Random round-trip sweep.
        for (int n = 0; n < 1000; n++) begin
            rm = W'($urandom);
            rd = W'($urandom);
            start_word(rm, rd, lat);
            if (lat < 0) begin
                check_q("rand_timeout", n, 32'd0, 32'd1);
            end else begin
                hb = b_out;
                hc = c_out;
                recon = (rm & deposit(hb, rm)) | (~rm & deposit(hc, ~rm));
                check_q("rand_roundtrip", n, 32'(recon), 32'(rd));
                check_q("rand_b_count", n, 32'(b_count), 32'(popcnt(rm)));
                check_q("rand_c_count", n, 32'(c_count), 32'(W - popcnt(rm)));
                hm = hb >> popcnt(rm);
                hd = hc >> (W - popcnt(rm));
                check_q("rand_upper_zero", n, {hm, hd}, 32'd0);
            end
            consume();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_choose_split
